// File: rtl/ws2812_frame_feeder.sv
// ws2812_frame_feeder: NUM_LEDS-entry pixel buffer plus frame sequencer for a WS2812 bit driver.
// Presents one pixel per valid/latched handshake, waits for the driver to drain, then holds the latch gap.
module ws2812_frame_feeder #(
    parameter int NUM_LEDS = 8,
    parameter int CLK_FREQ = 27_000_000,
    parameter int RESET_US = 50,
    localparam int ADDR_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic              clk_27M,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    output logic [23:0]       rgb_data,
    output logic              data_valid,
    input  logic              data_latched,
    input  logic              driver_busy,
    output logic              frame_busy,
    output logic              frame_done
);

    localparam int GAP_CYCLES = (CLK_FREQ / 1_000_000) * RESET_US;
    localparam int CNT_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_LEDS - 1);
    localparam logic [ADDR_W:0]   NUM_LEDS_W = (ADDR_W + 1)'(NUM_LEDS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRESENT,
        DRAIN,
        GAP,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  gap_cnt;
    logic [23:0]       pix_mem [NUM_LEDS];

    // Handshake: rgb_data is stable while data_valid is high; a data_latched pulse
    // while data_valid is high consumes the pixel, and is ignored while data_valid is low.

    // Writes are accepted in every state; out-of-range addresses are dropped.
    always_ff @(posedge clk_27M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                pix_mem[i] <= '0;
            end
        end else if (wr_en && ({1'b0, wr_addr} < NUM_LEDS_W)) begin
            pix_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_27M or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = LOAD;
            LOAD:    state_nxt = PRESENT;
            PRESENT: if (data_latched) state_nxt = (idx == LAST_IDX) ? DRAIN : LOAD;
            DRAIN:   if (!driver_busy) state_nxt = GAP;
            // Any busy cycle during the gap restarts the full gap.
            GAP:     if (!driver_busy && gap_cnt == GAP_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The LOAD read uses the pre-edge buffer value, so a same-cycle write is seen next frame.
    always_ff @(posedge clk_27M or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            gap_cnt    <= '0;
            rgb_data   <= '0;
            data_valid <= 1'b0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        idx        <= '0;
                        frame_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    rgb_data   <= pix_mem[idx];
                    data_valid <= 1'b1;
                end
                PRESENT: begin
                    if (data_latched) begin
                        data_valid <= 1'b0;
                        if (idx != LAST_IDX) idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    gap_cnt <= '0;
                end
                GAP: begin
                    if (driver_busy) gap_cnt <= '0;
                    else             gap_cnt <= gap_cnt + 1'b1;
                end
                DONE: begin
                    frame_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_feeder.sv
// Bench for ws2812_frame_feeder: a responder plays the LED driver, a monitor checks every
// presented pixel and every frame_done against expectation queues filled by the stimulus.
`timescale 1ns/1ps
module tb_ws2812_frame_feeder;

    localparam int N    = 8;
    localparam int AW   = 3;
    localparam int GAP  = (27_000_000 / 1_000_000) * 50;
    localparam int SN   = 5;
    localparam int SGAP = (2_000_000 / 1_000_000) * 3;

    // ---------------- clock / reset / signals ----------------
    logic          clk_27M = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = '0;
    logic [23:0]   rgb_data;
    logic          data_valid;
    logic          data_latched = 1'b0;
    logic          driver_busy = 1'b0;
    logic          frame_busy;
    logic          frame_done;

    logic          s_rst_n = 1'b0;
    logic          s_frame_start = 1'b0;
    logic          s_wr_en = 1'b0;
    logic [2:0]    s_wr_addr = '0;
    logic [23:0]   s_wr_data = '0;
    logic [23:0]   s_rgb_data;
    logic          s_data_valid;
    logic          s_data_latched = 1'b0;
    logic          s_driver_busy = 1'b0;
    logic          s_frame_busy;
    logic          s_frame_done;

    always #5 clk_27M = ~clk_27M;

    int cyc = 0;
    initial forever begin
        @(posedge clk_27M);
        cyc = cyc + 1;
    end

    ws2812_frame_feeder dut (
        .clk_27M      (clk_27M),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rgb_data     (rgb_data),
        .data_valid   (data_valid),
        .data_latched (data_latched),
        .driver_busy  (driver_busy),
        .frame_busy   (frame_busy),
        .frame_done   (frame_done)
    );

    ws2812_frame_feeder #(.NUM_LEDS(SN), .CLK_FREQ(2_000_000), .RESET_US(3)) dut_small (
        .clk_27M      (clk_27M),
        .rst_n        (s_rst_n),
        .frame_start  (s_frame_start),
        .wr_en        (s_wr_en),
        .wr_addr      (s_wr_addr),
        .wr_data      (s_wr_data),
        .rgb_data     (s_rgb_data),
        .data_valid   (s_data_valid),
        .data_latched (s_data_latched),
        .driver_busy  (s_driver_busy),
        .frame_busy   (s_frame_busy),
        .frame_done   (s_frame_done)
    );

    // ---------------- scoreboard state ----------------
    logic [23:0] exp_q[$];
    int          exp_done_q[$];
    int          exp_valid_cyc = 0;
    logic [23:0] model_buf [N];
    int          checks = 0;
    int          failures = 0;
    int          valid_rises = 0;
    int          done_seen = 0;

    // responder configuration
    int lat = 3;
    int busy_len = 800;
    int pulse_off = -1;
    int latch_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk_27M);
            if (rst_n) begin
                if (data_valid && !prev_valid) begin
                    valid_rises++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_pixel", 32'(data_valid), 32'd0);
                    end else begin
                        check("pixel", 32'(rgb_data), 32'(exp_q.pop_front()));
                        check("pixel_latency", cyc, exp_valid_cyc);
                    end
                end
                if (frame_done) begin
                    done_seen++;
                    check("done_with_busy", 32'(frame_busy), 32'd1);
                    if (exp_done_q.size() == 0) check("unexpected_done", 32'(frame_done), 32'd0);
                    else check("done_cycle", cyc, exp_done_q.pop_front());
                end
            end
            prev_valid = data_valid;
        end
    end

    // ---------------- driver model (responder) ----------------
    initial begin
        int f_cyc;
        forever begin
            @(negedge clk_27M);
            if (rst_n && data_valid) begin
                repeat (lat) @(negedge clk_27M);
                data_latched  = 1'b1;
                exp_valid_cyc = cyc + 2;
                latch_cnt++;
                @(negedge clk_27M);
                data_latched = 1'b0;
                if (latch_cnt == N) begin
                    latch_cnt = 0;
                    if (busy_len > 0) begin
                        driver_busy = 1'b1;
                        repeat (busy_len) @(negedge clk_27M);
                        driver_busy = 1'b0;
                    end
                    // first cycle the driver reports idle; the gap starts the cycle after
                    f_cyc = cyc;
                    if (pulse_off >= 0) begin
                        exp_done_q.push_back(f_cyc + 1 + pulse_off + GAP + 1);
                        repeat (1 + pulse_off) @(negedge clk_27M);
                        driver_busy = 1'b1;
                        @(negedge clk_27M);
                        driver_busy = 1'b0;
                    end else begin
                        exp_done_q.push_back(f_cyc + GAP + 1);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_drv(input int l, input int b, input int p);
        lat = l;
        busy_len = b;
        pulse_off = p;
    endtask

    task automatic write_pix(input int a, input logic [23:0] d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(negedge clk_27M);
        wr_en = 1'b0;
        if (a < N) model_buf[a] = d;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        exp_valid_cyc = cyc + 2;
        for (int k = 0; k < N; k++) exp_q.push_back(model_buf[k]);
        @(negedge clk_27M);
        frame_start = 1'b0;
        check("busy_after_start", 32'(frame_busy), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (!frame_done && t < budget) begin
            @(negedge clk_27M);
            t++;
        end
        check("done_timeout", 32'(t < budget), 32'd1);
        @(negedge clk_27M);
        check("busy_after_done", 32'(frame_busy), 32'd0);
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(negedge clk_27M);
        frame_start = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- main stimulus ----------------
    initial begin
        int n_high;
        int t;
        int r0;
        int d0;
        int s_start;
        int s_last;
        logic [23:0] sv [SN];

        for (int k = 0; k < N; k++) model_buf[k] = '0;

        // reset then idle
        repeat (5) @(negedge clk_27M);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_frame_busy", 32'(frame_busy), 32'd0);
        rst_n = 1'b1;
        s_rst_n = 1'b1;
        @(negedge clk_27M);
        check("idle_rgb_data", 32'(rgb_data), 32'd0);
        check("idle_data_valid", 32'(data_valid), 32'd0);
        check("idle_frame_busy", 32'(frame_busy), 32'd0);
        check("idle_frame_done", 32'(frame_done), 32'd0);
        n_high = 0;
        repeat (2000) begin
            @(negedge clk_27M);
            if (data_valid) n_high++;
        end
        check("idle_no_valid", n_high, 0);

        // reset-cleared buffer presents zeros
        set_drv(2, 0, -1);
        start_frame();
        wait_done(6000);

        // single frame with the reference pixel pattern
        for (int i = 0; i < N; i++) write_pix(i, 24'(32'h010000 * i + i));
        set_drv(3, 800, -1);
        start_frame();
        wait_done(6000);

        // busy pulse at gap count 600 restarts the gap
        set_drv(3, 800, 600);
        start_frame();
        wait_done(6000);

        // frame_start mid-frame and during the gap is ignored
        set_drv(3, 100, -1);
        r0 = valid_rises;
        d0 = done_seen;
        start_frame();
        repeat (18) @(negedge clk_27M);
        pulse_start();
        repeat (579) @(negedge clk_27M);
        pulse_start();
        wait_done(6000);
        repeat (20) @(negedge clk_27M);
        check("reject_pixel_count", valid_rises - r0, N);
        check("reject_done_count", done_seen - d0, 1);

        // frame_start on the frame_done cycle is ignored; the next cycle is accepted
        set_drv(1, 0, -1);
        start_frame();
        t = 0;
        while (!frame_done && t < 6000) begin
            @(negedge clk_27M);
            t++;
        end
        check("restart_reach_done", 32'(t < 6000), 32'd1);
        frame_start = 1'b1;
        @(negedge clk_27M);
        check("restart_not_taken_on_done", 32'(frame_busy), 32'd0);
        start_frame();
        wait_done(6000);

        // write collision on the LOAD cycle of index 3
        set_drv(3, 0, -1);
        r0 = valid_rises;
        start_frame();
        t = 0;
        while (!(valid_rises == r0 + 3 && !data_valid) && t < 200) begin
            @(negedge clk_27M);
            t++;
        end
        check("collision_reach_load", 32'(t < 200), 32'd1);
        write_pix(3, 24'hABCDEF);
        wait_done(6000);
        start_frame();
        wait_done(6000);

        // randomized frames
        for (int f = 0; f < 5; f++) begin
            int p;
            for (int k = 0; k < 6; k++) write_pix(int'($urandom_range(0, N - 1)), 24'($urandom));
            p = -1;
            if ($urandom_range(0, 1) == 1) p = int'($urandom_range(0, GAP - 1));
            set_drv(int'($urandom_range(1, 5)), int'($urandom_range(0, 900)), p);
            start_frame();
            wait_done(6000);
        end

        // async reset while pixel index 4 is presented
        set_drv(3, 0, -1);
        r0 = valid_rises;
        start_frame();
        t = 0;
        while (valid_rises != r0 + 5 && t < 200) begin
            @(negedge clk_27M);
            t++;
        end
        check("abort_reach_index4", 32'(t < 200), 32'd1);
        check("abort_valid_before", 32'(data_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid_async", 32'(data_valid), 32'd0);
        check("abort_busy_async", 32'(frame_busy), 32'd0);
        exp_q.delete();
        repeat (10) @(negedge clk_27M);
        latch_cnt = 0;
        for (int k = 0; k < N; k++) model_buf[k] = '0;
        rst_n = 1'b1;
        @(negedge clk_27M);
        for (int i = 0; i < 4; i++) write_pix(i, 24'($urandom));
        start_frame();
        wait_done(6000);

        // five-pixel instance: out-of-range addresses are dropped, last index stops at 4
        for (int k = 0; k < SN; k++) begin
            sv[k] = 24'($urandom);
            s_wr_en = 1'b1;
            s_wr_addr = 3'(k);
            s_wr_data = sv[k];
            @(negedge clk_27M);
        end
        for (int a = SN; a < 8; a++) begin
            s_wr_addr = 3'(a);
            s_wr_data = 24'hFFFFFF;
            @(negedge clk_27M);
        end
        s_wr_en = 1'b0;
        s_frame_start = 1'b1;
        s_start = cyc;
        @(negedge clk_27M);
        s_frame_start = 1'b0;
        s_last = 0;
        for (int k = 0; k < SN; k++) begin
            t = 0;
            while (!s_data_valid && t < 20) begin
                @(negedge clk_27M);
                t++;
            end
            if (k == 0) check("small_first_latency", cyc, s_start + 2);
            check("small_pixel", 32'(s_rgb_data), 32'(sv[k]));
            s_data_latched = 1'b1;
            s_last = cyc;
            @(negedge clk_27M);
            s_data_latched = 1'b0;
        end
        t = 0;
        while (!s_frame_done && t < 50) begin
            @(negedge clk_27M);
            t++;
        end
        check("small_done_cycle", cyc, s_last + 1 + SGAP + 1);
        n_high = 0;
        repeat (10) begin
            @(negedge clk_27M);
            if (s_data_valid) n_high++;
        end
        check("small_no_extra_pixel", n_high, 0);

        check("pixel_queue_drained", exp_q.size(), 0);
        check("done_queue_drained", exp_done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
